// File: rtl/axi_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter_pkg
// Shared encodings for the two-master AXI4 read/write arbiter:
//   - read FSM state encoding
//   - write FSM state encoding
//   - read grant encoding (which master owns the read channel)
//   - AXI INCR burst constant
// ---------------------------------------------------------------------------
package axi_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    localparam logic [1:0] INCR = 2'b01;

endpackage

// File: rtl/axi_arb_pick.sv
// ---------------------------------------------------------------------------
// axi_arb_pick
// Combinational two-input winner selector for the read channel.
// Build option: AXI_ARB_RR_EN (round-robin on a tie using last_grant;
// otherwise the LSU always beats the IFU).
// Ports:
//   req0       in   IFU read request (m0_ar_valid)
//   req1       in   LSU read request (m1_ar_valid)
//   last_grant in   master that completed the previous read (RR build only)
//   winner     out  selected master, GNT_IFU / GNT_LSU
// ---------------------------------------------------------------------------
module axi_arb_pick
    import axi_mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef AXI_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic winner
);

    always_comb begin
        winner = GNT_IFU;
        if (req0 && req1) begin
`ifdef AXI_ARB_RR_EN
            // On a tie the master that did not go last gets the channel.
            winner = ~last_grant;
`else
            winner = GNT_LSU;
`endif
        end else if (req1) begin
            winner = GNT_LSU;
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter
// Two-master (IFU = m0, read-only; LSU = m1, read/write) to one-slave AXI4
// arbiter. Reads are arbitrated per transaction and the grant is held from the
// AR handshake until the last R beat. Writes come only from the LSU and are
// sequenced AW -> W -> B by an independent FSM, concurrent with reads.
// Build option: AXI_ARB_RR_EN selects round-robin read arbitration
// (default: fixed priority, LSU over IFU).
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   m0_ar_*, m0_r_*              IFU read address / read data channels
//   m1_ar_*, m1_r_*              LSU read address / read data channels
//   m1_aw_*, m1_w_*, m1_b_*      LSU write address / data / response
//   s_ar_*, s_r_*, s_aw_*,
//   s_w_*, s_b_*                 slave-side mirror of the above
// ---------------------------------------------------------------------------
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    // IFU read
    input  logic                m0_ar_valid,
    output logic                m0_ar_ready,
    input  logic [ADDR_W-1:0]   m0_ar_addr,
    input  logic [7:0]          m0_ar_len,
    input  logic [2:0]          m0_ar_size,
    input  logic [1:0]          m0_ar_burst,
    output logic                m0_r_valid,
    input  logic                m0_r_ready,
    output logic [DATA_W-1:0]   m0_r_data,
    output logic                m0_r_last,
    // LSU read
    input  logic                m1_ar_valid,
    output logic                m1_ar_ready,
    input  logic [ADDR_W-1:0]   m1_ar_addr,
    input  logic [7:0]          m1_ar_len,
    input  logic [2:0]          m1_ar_size,
    input  logic [1:0]          m1_ar_burst,
    output logic                m1_r_valid,
    input  logic                m1_r_ready,
    output logic [DATA_W-1:0]   m1_r_data,
    output logic                m1_r_last,
    // LSU write
    input  logic                m1_aw_valid,
    output logic                m1_aw_ready,
    input  logic [ADDR_W-1:0]   m1_aw_addr,
    input  logic [7:0]          m1_aw_len,
    input  logic [2:0]          m1_aw_size,
    input  logic [1:0]          m1_aw_burst,
    input  logic                m1_w_valid,
    output logic                m1_w_ready,
    input  logic [DATA_W-1:0]   m1_w_data,
    input  logic [DATA_W/8-1:0] m1_w_strb,
    input  logic                m1_w_last,
    output logic                m1_b_valid,
    input  logic                m1_b_ready,
    // Slave read
    output logic                s_ar_valid,
    input  logic                s_ar_ready,
    output logic [ADDR_W-1:0]   s_ar_addr,
    output logic [7:0]          s_ar_len,
    output logic [2:0]          s_ar_size,
    output logic [1:0]          s_ar_burst,
    input  logic                s_r_valid,
    output logic                s_r_ready,
    input  logic [DATA_W-1:0]   s_r_data,
    input  logic                s_r_last,
    // Slave write
    output logic                s_aw_valid,
    input  logic                s_aw_ready,
    output logic [ADDR_W-1:0]   s_aw_addr,
    output logic [7:0]          s_aw_len,
    output logic [2:0]          s_aw_size,
    output logic [1:0]          s_aw_burst,
    output logic                s_w_valid,
    input  logic                s_w_ready,
    output logic [DATA_W-1:0]   s_w_data,
    output logic [DATA_W/8-1:0] s_w_strb,
    output logic                s_w_last,
    input  logic                s_b_valid,
    output logic                s_b_ready
);

    rd_state_t r_state_q, r_state_d;
    wr_state_t w_state_q, w_state_d;
    logic      grant_q, grant_d;
    logic      pick_winner;

`ifdef AXI_ARB_RR_EN
    logic last_grant_q;
`endif

    axi_arb_pick u_pick (
        .req0       (m0_ar_valid),
        .req1       (m1_ar_valid),
`ifdef AXI_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .winner     (pick_winner)
    );

    // AR payload follows the registered grant, so there is no path from a
    // master's valid to any ready within the same cycle.
    assign s_ar_addr  = (grant_q == GNT_LSU) ? m1_ar_addr  : m0_ar_addr;
    assign s_ar_len   = (grant_q == GNT_LSU) ? m1_ar_len   : m0_ar_len;
    assign s_ar_size  = (grant_q == GNT_LSU) ? m1_ar_size  : m0_ar_size;
    assign s_ar_burst = (grant_q == GNT_LSU) ? m1_ar_burst : m0_ar_burst;

    assign m0_r_data = s_r_data;
    assign m1_r_data = s_r_data;

    assign s_aw_addr  = m1_aw_addr;
    assign s_aw_len   = m1_aw_len;
    assign s_aw_size  = m1_aw_size;
    assign s_aw_burst = m1_aw_burst;
    assign s_w_data   = m1_w_data;
    assign s_w_strb   = m1_w_strb;
    assign s_w_last   = m1_w_last;

    // ---- read FSM state register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            grant_q   <= GNT_IFU;
        end else begin
            r_state_q <= r_state_d;
            grant_q   <= grant_d;
        end
    end

`ifdef AXI_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= GNT_IFU;
        end else if (r_state_q == R_DATA && s_r_valid && s_r_ready && s_r_last) begin
            last_grant_q <= grant_q;
        end
    end
`endif

    // ---- read FSM next state / outputs ----
    always_comb begin
        r_state_d   = r_state_q;
        grant_d     = grant_q;
        s_ar_valid  = 1'b0;
        m0_ar_ready = 1'b0;
        m1_ar_ready = 1'b0;
        s_r_ready   = 1'b0;
        m0_r_valid  = 1'b0;
        m1_r_valid  = 1'b0;
        m0_r_last   = 1'b0;
        m1_r_last   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (m0_ar_valid || m1_ar_valid) begin
                    grant_d   = pick_winner;
                    r_state_d = R_AR;
                end
            end
            R_AR: begin
                if (grant_q == GNT_LSU) begin
                    s_ar_valid  = m1_ar_valid;
                    m1_ar_ready = s_ar_ready;
                end else begin
                    s_ar_valid  = m0_ar_valid;
                    m0_ar_ready = s_ar_ready;
                end
                if (s_ar_valid && s_ar_ready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (grant_q == GNT_LSU) begin
                    m1_r_valid = s_r_valid;
                    m1_r_last  = s_r_last;
                    s_r_ready  = m1_r_ready;
                end else begin
                    m0_r_valid = s_r_valid;
                    m0_r_last  = s_r_last;
                    s_r_ready  = m0_r_ready;
                end
                if (s_r_valid && s_r_ready && s_r_last) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---- write FSM state register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    // ---- write FSM next state / outputs ----
    always_comb begin
        w_state_d   = w_state_q;
        s_aw_valid  = 1'b0;
        m1_aw_ready = 1'b0;
        s_w_valid   = 1'b0;
        m1_w_ready  = 1'b0;
        m1_b_valid  = 1'b0;
        s_b_ready   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (m1_aw_valid) begin
                    w_state_d = W_AW;
                end
            end
            W_AW: begin
                s_aw_valid  = m1_aw_valid;
                m1_aw_ready = s_aw_ready;
                if (m1_aw_valid && s_aw_ready) begin
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s_w_valid  = m1_w_valid;
                m1_w_ready = s_w_ready;
                if (m1_w_valid && s_w_ready && m1_w_last) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                m1_b_valid = s_b_valid;
                s_b_ready  = m1_b_ready;
                if (s_b_valid && m1_b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter between the CPU and the AXI SRAM/device slave.
- Master 0 is the instruction fetch unit (IFU, read-only); master 1 is the load/store unit (LSU, read and write).
- Reads are arbitrated transaction-by-transaction and the grant is held from AR handshake until the last R beat.
- Writes come only from master 1 and are sequenced AW -> W -> B independently of the read channel.

Parameters:
- ADDR_W, 64, address width of all AR/AW channels
- DATA_W, 64, data width of all R/W channels; strobe width is DATA_W/8

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m0_ar_valid/m0_ar_ready  in/out  1  IFU read-address handshake
- m0_ar_addr  in  ADDR_W; m0_ar_len in 8; m0_ar_size in 3; m0_ar_burst in 2  IFU AR payload
- m0_r_valid/m0_r_ready  out/in  1; m0_r_data out DATA_W; m0_r_last out 1  IFU R channel
- m1_ar_*, m1_r_*  same set as m0  LSU read channels
- m1_aw_valid/ready  in/out 1; m1_aw_addr in ADDR_W; m1_aw_len in 8; m1_aw_size in 3; m1_aw_burst in 2  LSU write address
- m1_w_valid/ready  in/out 1; m1_w_data in DATA_W; m1_w_strb in DATA_W/8; m1_w_last in 1  LSU write data
- m1_b_valid/ready  out/in 1  LSU write response
- s_ar_*, s_r_*, s_aw_*, s_w_*, s_b_*  mirror of the above toward the slave, opposite directions

Behaviour:
- Read FSM states: R_IDLE, R_AR, R_DATA. Register grant_q selects 0=IFU, 1=LSU.
- R_IDLE: if any m*_ar_valid, choose a winner (fixed priority LSU > IFU unless the RR feature is enabled), latch grant_q, go to R_AR. Arbitration adds exactly 1 cycle; no combinational valid->ready path.
- R_AR: s_ar_* = granted master's AR; s_ar_valid = granted m_ar_valid; granted m_ar_ready = s_ar_ready; the other master's ar_ready = 0. On handshake go to R_DATA.
- R_DATA: route s_r_* only to the granted master; non-granted r_valid = 0; s_r_ready = granted r_ready. On s_r_valid & s_r_ready & s_r_last go to R_IDLE. Burst lengths >0 are supported through r_last.
- Payload is held stable by the master while valid is high, as AXI requires. The arbiter never drops a valid once it is presented to the slave.
- Write FSM states: W_IDLE, W_AW, W_DATA, W_RESP.
  - W_IDLE -> W_AW when m1_aw_valid.
  - W_AW passes AW through and moves to W_DATA on handshake.
  - W_DATA passes W through and moves to W_RESP on a handshake with w_last.
  - W_RESP passes B through and moves to W_IDLE on b_valid & b_ready.
  - s_aw_valid/s_w_valid/s_b_ready are 0 outside their respective states.
- Read and write FSMs run concurrently. The slave must tolerate simultaneous read and write.
- Simultaneous m0/m1 AR in R_IDLE: LSU wins in fixed mode.
- A request arriving during R_AR/R_DATA waits; its ar_ready stays 0.
- Reset (any cycle, including mid-burst): both FSMs -> IDLE, grant_q=0, last_grant=0. All valid/ready outputs = 0 on the first cycle after reset. A slave transaction in flight is abandoned; the slave is reset together with the arbiter.
- Outputs toward masters:
  - m*_r_data mirrors s_r_data unconditionally.
  - Only valid/ready/last are gated.

Optional Feature:
- AXI_ARB_RR_EN: when defined, read arbitration is round-robin.
  - A last_grant register is updated on each completed read (r_last handshake).
  - On a tie, the master not in last_grant wins.
  - Without the macro, fixed priority applies: LSU always beats IFU, and last_grant logic is not compiled.

Decomposition:
- Shared package:
  - read state encoding (R_IDLE=0, R_AR=1, R_DATA=2)
  - write state encoding (W_IDLE=0, W_AW=1, W_DATA=2, W_RESP=3)
  - grant encoding (GNT_IFU=0, GNT_LSU=1)
  - AXI burst constant INCR=2'b01
- One natural sub-module: axi_arb_pick, the combinational 2-input winner selector (fixed or RR). The FSMs stay in the top level.

Test Plan:
- IFU only: m0 AR addr 0x8000_0000 len 0; slave ar_ready after 2 cycles, r_data 0x1122334455667788 last=1 -> m0 receives the data; m1_r_valid stays 0 throughout; grant issued 1 cycle after valid.
- Simultaneous m0 and m1 AR (0x8000_0000 / 0xa000_0048), fixed mode -> slave sees 0xa000_0048 first, then 0x8000_0000 after the LSU's r_last; m0_ar_ready stays 0 until then.
- RR enabled: m0 and m1 both request continuously for 4 transactions -> grant order LSU, IFU, LSU, IFU.
- Write: m1 AW 0xa000_03f8, W data 0x41 strb 0x01 last=1, slave b_valid 3 cycles later -> b passed to m1; FSM back in W_IDLE; a concurrent m0 read completes unaffected.
- Burst read len=3 on m0 while m1 requests in beat 2 -> all 4 beats go to m0; m1 is granted only after r_last.
- Reset asserted in R_DATA mid-burst -> next cycle all valid/ready outputs are 0 and the FSM is in R_IDLE; a fresh m0 request completes normally.
